// File: rtl/apbt1_lint_bridge_if.sv
// Bus bundle between the SoC LINT slave port and the eFPGA APB target.
// The bridge uses the slave view; the SoC/eFPGA environment uses the master view.
interface apbt1_lint_bridge_if #(
  parameter int AW = 20
);
  logic          lint_req;
  logic          lint_wen;
  logic [31:0]   lint_add;
  logic [3:0]    lint_be;
  logic [31:0]   lint_wdata;
  logic          lint_gnt;
  logic          lint_valid;
  logic [31:0]   lint_rdata;
  logic          efpga_req;
  logic [AW+36:0] efpga_req_data;
  logic          efpga_gnt;
  logic          efpga_valid;
  logic [31:0]   efpga_rdata;

  modport slave (
    input  lint_req, lint_wen, lint_add, lint_be, lint_wdata,
    output lint_gnt, lint_valid, lint_rdata,
    output efpga_req, efpga_req_data,
    input  efpga_gnt, efpga_valid, efpga_rdata
  );

  modport master (
    output lint_req, lint_wen, lint_add, lint_be, lint_wdata,
    input  lint_gnt, lint_valid, lint_rdata,
    input  efpga_req, efpga_req_data,
    output efpga_gnt, efpga_valid, efpga_rdata
  );
endinterface

// File: rtl/apbt1_lint_bridge.sv
// Single-clock LINT-to-eFPGA APB bridge: one captured request per LINT transaction,
// with a minimum grant delay and an auto-grant bypass when the bridge is disabled.
module apbt1_lint_bridge #(
  parameter int APB_FPGA_ADDR_WIDTH = 20
) (
  input  logic                 lint_clk,
  input  logic                 lint_rst,
  input  logic                 enable_apb_i,
  apbt1_lint_bridge_if.slave   bus
);
  localparam int AW = APB_FPGA_ADDR_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]     state_reg, state_next;
  logic [4:0]     d_reg;
  logic [AW+36:0] req_data_reg, req_data_next;
  logic [31:0]    rdata_reg, rdata_next;
  logic           start;
  logic           done;
  logic           is_read;

  // Upper LINT address bits are outside the eFPGA window and deliberately dropped.
  logic unused_add;
  assign unused_add = ^bus.lint_add[31:AW];

  // d[0]|d[1] is set from the second req cycle on, so start fires once per req assertion.
  assign start   = enable_apb_i & bus.lint_req & ~(d_reg[0] | d_reg[1]);
  assign done    = (state_reg == DONE);
  assign is_read = req_data_reg[AW+36];

  always_ff @(posedge lint_clk or posedge lint_rst) begin
    if (lint_rst) begin
      d_reg        <= '0;
      state_reg    <= IDLE;
      req_data_reg <= '0;
      rdata_reg    <= '0;
    end else begin
      d_reg        <= bus.lint_req ? {d_reg[3:0], 1'b1} : 5'b0;
      state_reg    <= state_next;
      req_data_reg <= req_data_next;
      rdata_reg    <= rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    req_data_next = req_data_reg;
    rdata_next    = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          req_data_next = {bus.lint_wen, bus.lint_add[AW-1:0], bus.lint_be, bus.lint_wdata};
          state_next    = REQ;
        end
      end
      REQ: begin
        if (bus.efpga_gnt) begin
          if (!is_read) begin
            state_next = DONE;
          end else if (bus.efpga_valid) begin
            rdata_next = bus.efpga_rdata;
            state_next = DONE;
          end else begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (bus.efpga_valid) begin
          rdata_next = bus.efpga_rdata;
          state_next = DONE;
        end
      end
      default: begin
        if (!bus.lint_req) state_next = IDLE;
      end
    endcase
  end

  // Request is decoded from state so reset removes it without waiting for a clock.
  assign bus.efpga_req      = (state_reg == REQ);
  assign bus.efpga_req_data = req_data_reg;

  // When disabled the port answers every request at once so the interconnect never stalls.
  assign bus.lint_gnt   = enable_apb_i ? (d_reg[4] & done) : bus.lint_req;
  assign bus.lint_valid = enable_apb_i ? done : 1'b1;
  assign bus.lint_rdata = rdata_reg;
endmodule

// File: tb/tb_apbt1_lint_bridge.sv
// Directed bench for apbt1_lint_bridge: a transaction-level model checked every cycle,
// plus literal expectations for grant timing, captured request data and read data.
module tb_apbt1_lint_bridge;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;

  apbt1_lint_bridge_if #(.AW(AW)) bus();

  apbt1_lint_bridge #(.APB_FPGA_ADDR_WIDTH(AW)) dut (
    .lint_clk     (clk),
    .lint_rst     (rst),
    .enable_apb_i (en),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: run = consecutive earlier cycles with req high; one outstanding
  // transaction at a time, tracked as issued / awaiting data / complete.
  int             run;
  bit             m_out, m_wait, m_done, m_start;
  logic [AW+36:0] m_cap;
  logic [31:0]    m_rdata;

  always begin
    @(negedge clk);
    if (rst) begin
      run = 0; m_out = 0; m_wait = 0; m_done = 0; m_cap = '0; m_rdata = '0;
    end
    chk("efpga_req", 64'(bus.efpga_req), 64'(m_out));
    chk("efpga_req_data", 64'(bus.efpga_req_data), 64'(m_cap));
    chk("lint_gnt", 64'(bus.lint_gnt), en ? 64'(run >= 5 && m_done) : 64'(bus.lint_req));
    chk("lint_valid", 64'(bus.lint_valid), en ? 64'(m_done) : 64'd1);
    chk("lint_rdata", 64'(bus.lint_rdata), 64'(m_rdata));
    if (!rst) begin
      if (bus.efpga_req && bus.efpga_gnt) hs_count++;
      m_start = en && bus.lint_req && (run == 0);
      if (!m_out && !m_wait && !m_done) begin
        if (m_start) begin
          m_out = 1;
          m_cap = {bus.lint_wen, bus.lint_add[AW-1:0], bus.lint_be, bus.lint_wdata};
        end
      end else if (m_out) begin
        if (bus.efpga_gnt) begin
          m_out = 0;
          if (!m_cap[AW+36]) m_done = 1;
          else if (bus.efpga_valid) begin m_rdata = bus.efpga_rdata; m_done = 1; end
          else m_wait = 1;
        end
      end else if (m_wait) begin
        if (bus.efpga_valid) begin m_rdata = bus.efpga_rdata; m_wait = 0; m_done = 1; end
      end else if (!bus.lint_req) begin
        m_done = 0;
      end
      run = bus.lint_req ? ((run < 31) ? run + 1 : run) : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the first cycle with lint_req high; efpga_req is expected from cycle 1.
  task automatic run_txn(input logic wen, input logic [31:0] add, input logic [3:0] be,
                         input logic [31:0] wdata, input int gnt_dly, input int vld_dly,
                         input logic [31:0] rd, input int hold,
                         output int first_gnt, output logic [AW+36:0] seen);
    int gk, vk;
    gk = 1 + gnt_dly;
    vk = gk + vld_dly;
    first_gnt = -1;
    seen = '0;
    bus.lint_req = 1'b1; bus.lint_wen = wen; bus.lint_add = add;
    bus.lint_be = be; bus.lint_wdata = wdata;
    for (int k = 0; k < 300; k++) begin
      bus.efpga_gnt   = (k == gk);
      bus.efpga_valid = wen && (k == vk);
      bus.efpga_rdata = (k == vk) ? rd : 32'h0;
      @(negedge clk);
      if (bus.efpga_req) seen = bus.efpga_req_data;
      if (first_gnt < 0 && bus.lint_gnt) first_gnt = k;
      tick();
      if (first_gnt >= 0 && k >= first_gnt + hold) break;
    end
    bus.lint_req = 1'b0; bus.efpga_gnt = 1'b0; bus.efpga_valid = 1'b0;
    tick();
    if (first_gnt < 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got no lint_gnt expected grant within 300 cycles");
    end
    $display("txn wen=%0d add=%h wdata=%h gnt_cycle=%0d rdata=%h",
             wen, add, wdata, first_gnt, bus.lint_rdata);
  endtask

  int             g;
  logic [AW+36:0] sd;

  initial begin
    rst = 1'b1; en = 1'b0;
    bus.lint_req = 0; bus.lint_wen = 0; bus.lint_add = 0; bus.lint_be = 0; bus.lint_wdata = 0;
    bus.efpga_gnt = 0; bus.efpga_valid = 0; bus.efpga_rdata = 0;
    repeat (3) tick();
    chk("rst_efpga_req", 64'(bus.efpga_req), 64'd0);
    chk("rst_valid_bypass", 64'(bus.lint_valid), 64'd1);
    chk("rst_rdata", 64'(bus.lint_rdata), 64'd0);
    en = 1'b1; #1;
    chk("rst_valid_enabled", 64'(bus.lint_valid), 64'd0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 1) bypass: granted in the very cycle req rises, nothing sent to the eFPGA
    bus.lint_req = 1'b1; #1;
    chk("t1_gnt_same_cycle", 64'(bus.lint_gnt), 64'd1);
    chk("t1_valid", 64'(bus.lint_valid), 64'd1);
    run_txn(1'b0, 32'h0000_0010, 4'h3, 32'h1111_2222, 0, 0, 32'h0, 0, g, sd);
    chk("t1_gnt_cycle", 64'(g), 64'd0);
    chk("t1_no_efpga_req", 64'(sd), 64'd0);

    // 2) enabled write, immediate eFPGA grant: grant waits for the 5-deep delay chain
    en = 1'b1;
    tick();
    run_txn(1'b0, 32'h1A10_0004, 4'hF, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, g, sd);
    chk("t2_req_data", 64'(sd), {7'b0, 1'b0, 20'h00004, 4'hF, 32'hDEAD_BEEF});
    chk("t2_gnt_cycle", 64'(g), 64'd5);

    // 3) read: eFPGA grant 3 cycles late, data 10 cycles after that
    run_txn(1'b1, 32'h1A10_0008, 4'hF, 32'h0, 3, 10, 32'h1234_5678, 0, g, sd);
    chk("t3_gnt_cycle", 64'(g), 64'd15);
    chk("t3_rdata", 64'(bus.lint_rdata), 64'h1234_5678);
    chk("t3_req_data", 64'(sd), {7'b0, 1'b1, 20'h00008, 4'hF, 32'h0});

    // 4) long hold in DONE must not re-issue to the eFPGA
    hs_count = 0;
    run_txn(1'b0, 32'h0000_0020, 4'h1, 32'hA5A5_A5A5, 1, 0, 32'h0, 20, g, sd);
    chk("t4_gnt_cycle", 64'(g), 64'd5);
    chk("t4_handshakes", 64'(hs_count), 64'd1);
    chk("t4_rdata_kept", 64'(bus.lint_rdata), 64'h1234_5678);

    // 5) enable drops while the request is with the eFPGA
    bus.lint_req = 1; bus.lint_wen = 1; bus.lint_add = 32'h1A10_0100; bus.lint_be = 4'hF;
    tick(); tick();
    en = 1'b0; #1;
    chk("t5_bypass_gnt", 64'(bus.lint_gnt), 64'd1);
    chk("t5_still_req", 64'(bus.efpga_req), 64'd1);
    tick();
    bus.efpga_gnt = 1; bus.efpga_valid = 1; bus.efpga_rdata = 32'hCAFE_F00D;
    tick();
    bus.efpga_gnt = 0; bus.efpga_valid = 0; bus.efpga_rdata = 0;
    tick(); tick();
    bus.lint_req = 0;
    tick(); tick();
    chk("t5_idle_req", 64'(bus.efpga_req), 64'd0);
    chk("t5_rdata", 64'(bus.lint_rdata), 64'hCAFE_F00D);
    en = 1'b1;
    tick();
    $display("txn enable-drop read rdata=%h", bus.lint_rdata);

    // 6) reset while waiting for read data
    bus.lint_req = 1; bus.lint_wen = 1; bus.lint_add = 32'h0000_0040;
    tick();
    bus.efpga_gnt = 1;
    tick();
    bus.efpga_gnt = 0;
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_efpga_req", 64'(bus.efpga_req), 64'd0);
    chk("t6_rst_rdata", 64'(bus.lint_rdata), 64'd0);
    tick();
    rst = 1'b0; bus.lint_req = 0;
    tick();
    $display("txn reset-in-RESP read rdata=%h", bus.lint_rdata);
    run_txn(1'b1, 32'hFFF0_0044, 4'hC, 32'h0, 1, 2, 32'h0BAD_F00D, 0, g, sd);
    chk("t6_next_gnt_cycle", 64'(g), 64'd5);
    chk("t6_next_rdata", 64'(bus.lint_rdata), 64'h0BAD_F00D);
    chk("t6_next_req_data", 64'(sd), {7'b0, 1'b1, 20'h00044, 4'hC, 32'h0});

    // 7) req withdrawn before grant: bridge finishes and idles
    bus.lint_req = 1; bus.lint_wen = 1; bus.lint_add = 32'h0000_0050;
    tick();
    bus.efpga_gnt = 1; bus.efpga_valid = 1; bus.efpga_rdata = 32'h55AA_55AA;
    tick();
    bus.efpga_gnt = 0; bus.efpga_valid = 0; bus.lint_req = 0;
    tick();
    chk("t7_idle_valid", 64'(bus.lint_valid), 64'd0);
    chk("t7_rdata", 64'(bus.lint_rdata), 64'h55AA_55AA);
    tick();
    $display("txn early-drop read rdata=%h", bus.lint_rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
